// File: rtl/pcb_ctrl_pkg.sv
// Shared board-control types and default timing constants for the button
// conditioner and the LED blinker.
package pcb_ctrl_pkg;

  localparam int CLK_HZ        = 100_000_000;
  localparam int DEBOUNCE_MS   = 10;
  localparam int LONG_PRESS_MS = 2000;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs. Both flops load RST_VAL
// on synchronous reset so the output is well defined from the first cycle.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: sync -> polarity normalise -> debounce FSM -> event pulses.
// Define LONG_PRESS_EN to enable the long-press counter and long_press_pulse.
//
// state        | meaning
// IDLE         | released, stable
// PRESS_WAIT   | press seen, dwelling before accepting it
// PRESSED      | press accepted (long-press counting when enabled)
// RELEASE_WAIT | release seen, dwelling before accepting it
module button_debounce
  import pcb_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CNT_MAX   = CLK_HZ / 1000 * DEBOUNCE_MS,
  parameter int LONG_PRESS_CNT_MAX = CLK_HZ / 1000 * LONG_PRESS_MS,
  parameter bit ACTIVE_LOW         = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse
);

`ifdef LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  localparam int CNT_SPAN = LONG_EN ? max_int(DEBOUNCE_CNT_MAX, LONG_PRESS_CNT_MAX)
                                    : DEBOUNCE_CNT_MAX;
  localparam int CNT_W    = $clog2(CNT_SPAN) + 1;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CNT_MAX - 1);
`endif

  logic       sync_q;
  logic       smp;
  btn_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       press_q, press_d;
  logic       release_q, release_d;
`ifdef LONG_PRESS_EN
  logic       long_q, long_d;
  logic       fired_q, fired_d;
`endif

  // Sync flops reset to the raw released level so no false press appears after reset.
  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (ACTIVE_LOW ? 1'b1 : 1'b0)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (btn_in),
    .q_o   (sync_q)
  );

  assign smp = sync_q ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef LONG_PRESS_EN
      long_q    <= 1'b0;
      fired_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef LONG_PRESS_EN
      long_q    <= long_d;
      fired_q   <= fired_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef LONG_PRESS_EN
    long_d    = 1'b0;
    fired_d   = fired_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef LONG_PRESS_EN
        fired_d = 1'b0;
`endif
        if (smp) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!smp) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!smp) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
`ifdef LONG_PRESS_EN
        // Once fired, cnt holds at LONG_LAST until the press ends.
        else if (!fired_q) begin
          if (cnt_q == LONG_LAST) begin
            long_d  = 1'b1;
            fired_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
`endif
      end
      RELEASE_WAIT: begin
        if (smp) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
`ifdef LONG_PRESS_EN
  assign long_press_pulse = long_q;
`else
  assign long_press_pulse = 1'b0;
`endif

endmodule
